// File: rtl/pin_pulse_gen_if.sv
// Control/status bundle between the event logic (master) and the pulse generator (slave).
interface pin_pulse_gen_if #(
    parameter int WIDTH = 16
);
    logic             ena;
    logic             trig;
    logic [WIDTH-1:0] delay_val;
    logic [WIDTH-1:0] width_val;
    logic             pol;
    logic             force_off;
    logic             q;
    logic             busy;
    logic             done;
    logic             ovr;

    modport master (
        output ena, trig, delay_val, width_val, pol, force_off,
        input  q, busy, done, ovr
    );

    modport slave (
        input  ena, trig, delay_val, width_val, pol, force_off,
        output q, busy, done, ovr
    );
endinterface

// File: rtl/pin_pulse_gen.sv
// Turns a one-cycle event strobe into a pin pulse with programmable start delay,
// width and polarity; one shared counter times both the DELAY and ACTIVE phases.
module pin_pulse_gen #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    pin_pulse_gen_if.slave   pp
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_ACTIVE = 2'd2
    } state_e;

    state_e           state_q,  state_d;
    logic [WIDTH-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] dly_q,    dly_d;
    logic [WIDTH-1:0] wid_q,    wid_d;
    logic             active_q, active_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;
    logic             ovr_q,    ovr_d;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        dly_d    = dly_q;
        wid_d    = wid_q;
        active_d = active_q;
        done_d   = 1'b0;
        ovr_d    = 1'b0;

        if (pp.force_off) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            active_d = 1'b0;
        end else if (pp.ena) begin
            unique case (state_q)
                S_IDLE: begin
                    if (pp.trig) begin
                        dly_d = pp.delay_val;
                        wid_d = pp.width_val;
                        cnt_d = '0;
                        if (pp.delay_val != '0) begin
                            state_d = S_DELAY;
                        end else if (pp.width_val != '0) begin
                            state_d  = S_ACTIVE;
                            active_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    ovr_d = pp.trig;
                    // Terminal compare at D-1 means the counter never wraps, even for D = 2^WIDTH-1.
                    if (cnt_q == dly_q - WIDTH'(1)) begin
                        cnt_d = '0;
                        if (wid_q != '0) begin
                            state_d  = S_ACTIVE;
                            active_d = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                S_ACTIVE: begin
                    ovr_d = pp.trig;
                    if (cnt_q == wid_q - WIDTH'(1)) begin
                        state_d  = S_IDLE;
                        cnt_d    = '0;
                        active_d = 1'b0;
                        done_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + WIDTH'(1);
                    end
                end
                default: begin
                    state_d  = S_IDLE;
                    cnt_d    = '0;
                    active_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            dly_q    <= '0;
            wid_q    <= '0;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values of the others.
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            dly_q    <= dly_d;
            wid_q    <= wid_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
        end
    end

    // Polarity is applied after the flop so reset immediately drives the idle level.
    assign pp.q    = active_q ^ pp.pol;
    assign pp.busy = busy_q;
    assign pp.done = done_q;
    assign pp.ovr  = ovr_q;
endmodule

// File: tb/tb_pin_pulse_gen.sv
// Directed bench for pin_pulse_gen: table of per-edge vectors plus hand sequences
// for abort, asynchronous reset and maximum delay.
module tb_pin_pulse_gen;
    localparam int WIDTH = 16;

    typedef struct {
        logic             ena;
        logic             trig;
        logic [WIDTH-1:0] dv;
        logic [WIDTH-1:0] wv;
        logic             pol;
        logic             fo;
        logic             eq;
        logic             eb;
        logic             ed;
        logic             eo;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    vec_t vecs[$];

    pin_pulse_gen_if #(.WIDTH(WIDTH)) bus ();

    pin_pulse_gen #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .pp  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic eq, input logic eb,
                              input logic ed, input logic eo);
        check({tag, " q"},    bus.q,    eq);
        check({tag, " busy"}, bus.busy, eb);
        check({tag, " done"}, bus.done, ed);
        check({tag, " ovr"},  bus.ovr,  eo);
    endtask

    task automatic drive(input logic ena, input logic trig, input logic [WIDTH-1:0] dv,
                         input logic [WIDTH-1:0] wv, input logic pol, input logic fo);
        bus.ena       = ena;
        bus.trig      = trig;
        bus.delay_val = dv;
        bus.width_val = wv;
        bus.pol       = pol;
        bus.force_off = fo;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic ena, input logic trig, input int dv, input int wv,
                       input logic pol, input logic fo, input logic eq, input logic eb,
                       input logic ed, input logic eo);
        vec_t v;
        v.ena = ena;  v.trig = trig;  v.dv = WIDTH'(dv);  v.wv = WIDTH'(wv);
        v.pol = pol;  v.fo = fo;      v.eq = eq;  v.eb = eb;  v.ed = ed;  v.eo = eo;
        vecs.push_back(v);
    endtask

    initial begin
        bool_wide_check : begin end
        drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0);

        // Reset state, both polarities.
        #2;
        check_outs("reset pol0", 1'b0, 1'b0, 1'b0, 1'b0);
        bus.pol = 1'b1;
        #1;
        check("reset pol1 q", bus.q, 1'b1);
        bus.pol = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();

        // Basic pulse, pol=0, D=3, W=5; inputs changed mid-pulse must not matter.
        add(1,1,3,5,0,0, 0,1,0,0);
        add(1,0,7,9,0,0, 0,1,0,0);
        add(1,0,7,9,0,0, 0,1,0,0);
        for (int i = 0; i < 5; i++) add(1,0,7,9,0,0, 1,1,0,0);
        add(1,0,0,0,0,0, 0,0,1,0);
        add(1,0,0,0,0,0, 0,0,0,0);
        // pol=1, D=0, W=2.
        add(1,1,0,2,1,0, 0,1,0,0);
        add(1,0,0,0,1,0, 0,1,0,0);
        add(1,0,0,0,1,0, 1,0,1,0);
        // pol=1, D=0, W=0: done only.
        add(1,1,0,0,1,0, 1,0,1,0);
        add(1,0,0,0,1,0, 1,0,0,0);
        // Overrun during pulse and on the completion edge.
        add(1,1,2,4,0,0, 0,1,0,0);
        add(1,0,0,0,0,0, 0,1,0,0);
        add(1,0,0,0,0,0, 1,1,0,0);
        add(1,1,5,5,0,0, 1,1,0,1);
        add(1,0,0,0,0,0, 1,1,0,0);
        add(1,0,0,0,0,0, 1,1,0,0);
        add(1,1,5,5,0,0, 0,0,1,1);
        add(1,0,0,0,0,0, 0,0,0,0);
        // Enable gating, D=1, W=3; trig while ena=0 gives no ovr.
        add(1,1,1,3,0,0, 0,1,0,0);
        add(0,1,0,0,0,0, 0,1,0,0);
        add(1,0,0,0,0,0, 1,1,0,0);
        add(0,0,0,0,0,0, 1,1,0,0);
        add(1,0,0,0,0,0, 1,1,0,0);
        add(0,0,0,0,0,0, 1,1,0,0);
        add(1,0,0,0,0,0, 1,1,0,0);
        add(0,0,0,0,0,0, 1,1,0,0);
        add(1,0,0,0,0,0, 0,0,1,0);
        add(0,0,0,0,0,0, 0,0,0,0);
        add(0,1,2,2,0,0, 0,0,0,0);
        add(1,0,0,0,0,0, 0,0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].ena, vecs[i].trig, vecs[i].dv, vecs[i].wv, vecs[i].pol, vecs[i].fo);
            step();
            check_outs($sformatf("row%0d", i), vecs[i].eq, vecs[i].eb, vecs[i].ed, vecs[i].eo);
        end

        // force_off on the second ACTIVE edge, with ena=0 and trig on the same edge.
        drive(1'b1, 1'b1, 16'd1, 16'd5, 1'b0, 1'b0);  step();
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);  step();
        check_outs("fo active", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 16'd0, 16'd0, 1'b0, 1'b1);  step();
        check_outs("fo abort", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);  step();
        check_outs("fo after", 1'b0, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'd0, 16'd1, 1'b0, 1'b0);  step();
        check_outs("fo fresh", 1'b1, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);  step();
        check_outs("fo fresh end", 1'b0, 1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-DELAY, pol=1.
        drive(1'b1, 1'b1, 16'd10, 16'd2, 1'b1, 1'b0);  step();
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0);   step();
        check("rst pre busy", bus.busy, 1'b1);
        #2;
        rst = 1'b0;
        #1;
        check_outs("rst async", 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        step();
        check_outs("rst idle", 1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 16'd0, 16'd1, 1'b1, 1'b0);  step();
        check_outs("rst new", 1'b0, 1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b1, 1'b0);  step();
        check_outs("rst new end", 1'b1, 1'b0, 1'b1, 1'b0);

        // Maximum delay: D=65535, W=1, pol=0.
        drive(1'b1, 1'b1, 16'hFFFF, 16'd1, 1'b0, 1'b0);  step();
        drive(1'b1, 1'b0, 16'd0, 16'd0, 1'b0, 1'b0);
        begin
            int bad = 0;
            for (int i = 1; i < 65535; i++) begin
                step();
                if (bus.q !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) bad++;
            end
            check("wide delay hold", (bad == 0), 1'b1);
        end
        step();
        check_outs("wide active", 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        check_outs("wide end", 1'b0, 1'b0, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/pin_pulse_gen.md
Name: pin_pulse_gen

Overview:
- Output-side counterpart of the capture input filter and edge detector.
- Converts a single-cycle event strobe (typically a filtered edge0/edge1) into a pulse on an output pin.
- Pulse has a programmable start delay and a programmable width, both counted in enabled clock cycles, with selectable active polarity.
- Sits between the angle/event logic and the ignition/injector pin drivers.

Parameters:
- WIDTH, 16, width of the delay and width counters and their load values.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-low reset.
- ena  input  1  clock enable (tick); when 0 the block is frozen.
- trig  input  1  start strobe, sampled on rising clk edges with ena=1.
- delay_val  input  WIDTH  cycles from the trigger to the start of the pulse; latched on trigger acceptance.
- width_val  input  WIDTH  pulse length in cycles; latched on trigger acceptance.
- pol  input  1  0 = active-high pulse, idle low; 1 = active-low pulse, idle high. Quasi-static.
- force_off  input  1  synchronous abort.
- q  output  1  pin drive.
- busy  output  1  high while in DELAY or ACTIVE.
- done  output  1  one-cycle pulse on normal pulse completion.
- ovr  output  1  one-cycle pulse when a trigger arrives while busy.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, counter=0, latched values=0, active flag=0.
  - busy=0, done=0, ovr=0, q=pol (idle level).
- q = active_flag XOR pol.
  - active_flag is a register, so q changes only on clk edges, except when pol is changed (pol is not changed while busy).
- States are IDLE, DELAY and ACTIVE. One WIDTH-bit counter serves both phases.
- IDLE, edge k with ena=1 and trig=1:
  - Latch D=delay_val and W=width_val; counter=0.
  - If D>0: go to DELAY.
  - If D=0 and W>0: go to ACTIVE, active_flag=1 after edge k.
  - If D=0 and W=0: stay IDLE, done=1 for the cycle after edge k, q never leaves idle.
- DELAY: counter increments on each enabled edge.
  - When counter==D-1 on an enabled edge, go to ACTIVE, counter=0, active_flag=1.
  - If W=0, go instead to IDLE and assert done with no active cycle.
  - Net effect: q is active starting after edge k+D.
- ACTIVE: counter increments on each enabled edge.
  - When counter==W-1 on an enabled edge, go to IDLE, active_flag=0, done=1 for one cycle.
  - q is active for exactly W enabled cycles, i.e. it leaves active after edge k+D+W.
- busy is registered: 1 in the cycles where state is DELAY or ACTIVE.
- A trigger is accepted only if the registered state is IDLE at that edge.
  - trig=1 with ena=1 in DELAY or ACTIVE: ignored; ovr=1 for the following cycle; the running pulse is unaffected.
  - A trig on the edge where ACTIVE completes counts as overrun. Back-to-back pulses therefore need at least one IDLE cycle between them.
- ena=0:
  - State, counter and active_flag hold.
  - trig is ignored and produces no ovr.
  - done and ovr drop to 0 after the next edge.
- force_off=1 at an edge (regardless of ena):
  - state=IDLE, counter=0, active_flag=0, so q goes idle after that edge.
  - No done; any trig on the same edge is ignored.
  - force_off has priority over everything except rst.
- Counter arithmetic is unsigned WIDTH-bit. D and W up to 2^WIDTH-1 are supported; no wrap occurs because comparisons terminate counting at D-1 and W-1.
- delay_val and width_val changes while busy have no effect on the running pulse.
- rst asserted mid-pulse: q returns to pol immediately (asynchronously); all flags clear.

Test Plan:
- Basic pulse: pol=0, ena=1, D=3, W=5, trig at edge 10 → q=1 after edges 13..17 (5 cycles), q=0 after edge 18; done=1 the cycle after edge 18; busy=1 after edges 10..17.
- Zero cases (pol=1):
  - D=0, W=2, trig at edge 4 → q=0 after edges 4..5, q=1 after edge 6, done after edge 6.
  - D=0, W=0 → q stays 1, done after edge 4, busy stays 0.
- Overrun: D=2, W=4, trig at edge 0 and edge 3 → ovr=1 the cycle after edge 3; pulse timing unchanged (q active after edges 2..5).
- Enable gating: D=1, W=3, ena toggling 1,0,1,0,… from trig → active length is 3 enabled edges, i.e. 6 clocks; a trig during an ena=0 cycle produces no ovr.
- Abort and reset:
  - force_off at edge 2 of ACTIVE → q idle after that edge, no done, busy=0; the next trig starts a fresh pulse with new values.
  - rst pulled low mid-DELAY → q=pol, busy=0 asynchronously; after release the block is IDLE.
- Wide values: WIDTH=16, D=65535, W=1 → q active for exactly 1 cycle after edge k+65535; no counter wrap glitch.
